weight_image_server: RTL

- ITCM-side responder for the accelerator's weight DMA. The DMA issues a weight word address each cycle and takes the data back on a fixed 1-cycle latency.
- The block holds the complete weight image in a local register array: 162 conv words followed by 1296 FC words, 1458 words total.
- The image is loaded beforehand from a host-side valid/ready stream.
- Once the image is complete and the word count matches, `o_image_ready` is asserted. This signal gates the accelerator start.

---
 rtl/weight_image_pkg.sv | 7 +
 rtl/weight_image_mem.sv | 34 +++
 rtl/weight_image_server.sv | 85 ++++++++
 3 files changed

// File: rtl/weight_image_pkg.sv
// weight_image_pkg: shared FSM state type and weight image length constants
package weight_image_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, READY, ERR} state_e;
  localparam int CONV_WEIGHT_LEN = 162;
  localparam int FC_WEIGHT_LEN = 1296;
  localparam int IMAGE_LEN = CONV_WEIGHT_LEN + FC_WEIGHT_LEN;
endpackage

// File: rtl/weight_image_mem.sv
// weight_image_mem: weight store (i_we/i_waddr/i_wdata write; i_raddr -> registered o_rd_data/o_rd_oob, masked unless i_serve and i_raddr < i_len)
module weight_image_mem
  import weight_image_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int DEPTH = IMAGE_LEN,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [IW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  input  logic          i_serve,
  input  logic [AW-1:0] i_len,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_oob
);
  logic [DW-1:0] mem_q [DEPTH];
  logic hit;
  assign hit = i_serve && i_raddr < i_len;
  always_ff @(posedge i_clk)
    if (i_we) mem_q[i_waddr] <= i_wdata;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      o_rd_data <= '0;
      o_rd_oob <= 1'b0;
    end else begin
      o_rd_data <= hit ? mem_q[i_raddr[IW-1:0]] : '0;
      o_rd_oob <= !hit;
    end
endmodule

// File: rtl/weight_image_server.sv
// weight_image_server: host stream (i_load_start/i_image_len, i_wr_*/o_wr_ready) fills the weight image; DMA reads via i_rd_addr -> o_rd_data/o_rd_oob; status o_image_ready/o_load_err/o_checksum
module weight_image_server
  import weight_image_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int DEPTH = IMAGE_LEN
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load_start,
  input  logic [AW-1:0] i_image_len,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_wr_last,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_oob,
  output logic          o_image_ready,
  output logic          o_load_err,
  output logic [DW-1:0] o_checksum
);
  localparam int IW = $clog2(DEPTH);
  state_e state_q, state_d;
  logic [AW-1:0] len_q, len_d, wptr_q, wptr_d;
  logic [DW-1:0] csum_q, csum_d;
  logic err_q, err_d;
  logic we, last_word, bad_len, good_end;
  assign o_wr_ready = state_q == LOAD;
  assign o_image_ready = state_q == READY;
  assign o_load_err = err_q;
  assign o_checksum = csum_q;
  assign we = i_wr_valid && o_wr_ready && !i_load_start;
  assign last_word = wptr_q == len_q - AW'(1);
  assign good_end = last_word && i_wr_last;
  assign bad_len = i_image_len == '0 || i_image_len > AW'(DEPTH);
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    wptr_d = wptr_q;
    csum_d = csum_q;
    err_d = err_q;
    if (i_load_start) begin
      len_d = i_image_len;
      state_d = bad_len ? ERR : LOAD;
      err_d = bad_len;
      wptr_d = bad_len ? wptr_q : '0;
      csum_d = bad_len ? csum_q : '0;
    end else if (we) begin
      wptr_d = last_word ? wptr_q : wptr_q + AW'(1);
      csum_d = csum_q + i_wr_data;
      if (last_word || i_wr_last) begin
        state_d = good_end ? READY : ERR;
        err_d = !good_end;
      end
    end
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state_q <= IDLE;
      len_q <= '0;
      wptr_q <= '0;
      csum_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      wptr_q <= wptr_d;
      csum_q <= csum_d;
      err_q <= err_d;
    end
  weight_image_mem #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_mem (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (we),
    .i_waddr  (wptr_q[IW-1:0]),
    .i_wdata  (i_wr_data),
    .i_raddr  (i_rd_addr),
    .i_serve  (state_q == READY),
    .i_len    (len_q),
    .o_rd_data(o_rd_data),
    .o_rd_oob (o_rd_oob)
  );
endmodule
